// File: rtl/branch_redirect_ctrl.sv
// Control-hazard sequencer: registers a taken branch/jump from EX, drives the PC redirect until fetch
// accepts it, then flushes IF for FLUSH_DEPTH cycles. Optional statistics counter: BJ_CTRL_STATS_EN.
module branch_redirect_ctrl #(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 2
`ifdef BJ_CTRL_STATS_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_Valid_ex,
    input  logic            i_B_J_taken,
    input  logic [XLEN-1:0] i_Target,
    input  logic            i_Imem_ready,
    input  logic            i_Stall_req,
    output logic            o_Pc_sel,
    output logic [XLEN-1:0] o_Pc_target,
    output logic            o_Flush_if,
    output logic            o_Flush_id,
    output logic            o_Stall,
    output logic            o_Busy
`ifdef BJ_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] o_Redirect_count
`endif
);

    // Redirect handshake: o_Pc_sel is valid, i_Imem_ready is ready; the redirect transfers on a rising
    // edge where both are high, and o_Pc_sel/o_Pc_target stay stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [XLEN-1:0]   r_target;
    logic [XLEN-1:0]   w_target_nxt;
    logic              w_accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_accept     = 1'b0;
        o_Pc_sel     = 1'b0;
        o_Flush_if   = 1'b0;
        o_Flush_id   = 1'b0;
        o_Stall      = i_Stall_req;
        case (r_state)
            S_IDLE: begin
                if (i_Valid_ex && i_B_J_taken) begin
                    // Bit 0 is cleared so JALR targets are always halfword aligned.
                    w_target_nxt = i_Target & ~XLEN'(1);
                    w_state_nxt  = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                o_Pc_sel   = 1'b1;
                o_Flush_if = 1'b1;
                o_Flush_id = 1'b1;
                o_Stall    = ~i_Imem_ready;
                if (i_Imem_ready) begin
                    w_accept = 1'b1;
                    if (FLUSH_DEPTH == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = DRAIN_LOAD;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                o_Flush_if = 1'b1;
                w_cnt_nxt  = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_Pc_target = r_target;
    assign o_Busy      = (r_state != S_IDLE);

`ifdef BJ_CTRL_STATS_EN
    logic [CNT_W-1:0] r_redirect_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_count <= '0;
        end else if (w_accept && (r_redirect_count != {CNT_W{1'b1}})) begin
            r_redirect_count <= r_redirect_count + CNT_W'(1);
        end
    end

    assign o_Redirect_count = r_redirect_count;
`else
    logic w_accept_unused;
    assign w_accept_unused = w_accept;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed test-plan sequences plus random stimulus,
// compared each cycle against a phase-level reference model through an expected-output queue.
module tb_branch_redirect_ctrl;

    localparam int XLEN        = 32;
    localparam int FLUSH_DEPTH = 2;
`ifdef BJ_CTRL_STATS_EN
    localparam int CNT_W = 2;
    localparam int EW    = XLEN + 5 + CNT_W;
`else
    localparam int EW    = XLEN + 5;
`endif

    logic            clk;
    logic            rst_n;
    logic            valid_ex;
    logic            bj_taken;
    logic [XLEN-1:0] target;
    logic            imem_ready;
    logic            stall_req;
    logic            pc_sel;
    logic [XLEN-1:0] pc_target;
    logic            flush_if;
    logic            flush_id;
    logic            stall;
    logic            busy;
`ifdef BJ_CTRL_STATS_EN
    logic [CNT_W-1:0] redirect_count;
`endif

    branch_redirect_ctrl #(
        .XLEN        (XLEN),
        .FLUSH_DEPTH (FLUSH_DEPTH)
`ifdef BJ_CTRL_STATS_EN
        ,
        .CNT_W       (CNT_W)
`endif
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_Valid_ex   (valid_ex),
        .i_B_J_taken  (bj_taken),
        .i_Target     (target),
        .i_Imem_ready (imem_ready),
        .i_Stall_req  (stall_req),
        .o_Pc_sel     (pc_sel),
        .o_Pc_target  (pc_target),
        .o_Flush_if   (flush_if),
        .o_Flush_id   (flush_id),
        .o_Stall      (stall),
        .o_Busy       (busy)
`ifdef BJ_CTRL_STATS_EN
        ,
        .o_Redirect_count (redirect_count)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n      = 1'b0;
        valid_ex   = 1'b0;
        bj_taken   = 1'b0;
        target     = '0;
        imem_ready = 1'b0;
        stall_req  = 1'b0;
    end

    // Reference model: redirect pending flag plus remaining flush cycles.
    logic [EW-1:0]   exp_q[$];
    int              errors = 0;
    int              checks = 0;
    bit              m_redirect_pending = 1'b0;
    int              m_flush_left = 0;
    logic [XLEN-1:0] m_target = '0;
    int              m_redirects = 0;

    function automatic logic [EW-1:0] pack_outputs(bit sel, bit fif, bit fid, bit stl, bit bsy,
                                                   logic [XLEN-1:0] tgt, int count);
        logic [EW-1:0] v;
`ifdef BJ_CTRL_STATS_EN
        v = {sel, fif, fid, stl, bsy, tgt, CNT_W'(count)};
`else
        v = {sel, fif, fid, stl, bsy, tgt};
        if (count < 0) v = '0;
`endif
        return v;
    endfunction

    // Driver: applies one cycle of inputs at the falling edge and queues the expected response.
    task automatic drive_cycle(input bit rst, input bit v, input bit t, input logic [XLEN-1:0] tgt,
                               input bit rdy, input bit stl);
        bit busy_e;
        int shown_count;
        @(negedge clk);
        rst_n      = rst;
        valid_ex   = v;
        bj_taken   = t;
        target     = tgt;
        imem_ready = rdy;
        stall_req  = stl;
        if (!rst) begin
            m_redirect_pending = 1'b0;
            m_flush_left       = 0;
            m_target           = '0;
            m_redirects        = 0;
        end
        busy_e = m_redirect_pending || (m_flush_left > 0);
`ifdef BJ_CTRL_STATS_EN
        shown_count = (m_redirects > (2**CNT_W - 1)) ? (2**CNT_W - 1) : m_redirects;
`else
        shown_count = m_redirects;
`endif
        exp_q.push_back(pack_outputs(m_redirect_pending, busy_e, m_redirect_pending,
                                     m_redirect_pending ? !rdy : stl, busy_e, m_target,
                                     shown_count));
        if (rst) begin
            if (m_redirect_pending) begin
                if (rdy) begin
                    m_redirect_pending = 1'b0;
                    m_flush_left       = FLUSH_DEPTH;
                    m_redirects        = m_redirects + 1;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left = m_flush_left - 1;
            end else if (v && t) begin
                m_redirect_pending = 1'b1;
                m_target           = {tgt[XLEN-1:1], 1'b0};
            end
        end
    endtask

    // Monitor: samples away from the rising edge and compares against the queue head.
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
`ifdef BJ_CTRL_STATS_EN
                got = {pc_sel, flush_if, flush_id, stall, busy, pc_target, redirect_count};
`else
                got = {pc_sel, flush_if, flush_id, stall, busy, pc_target};
`endif
                checks = checks + 1;
                if (got !== exp) begin
                    errors = errors + 1;
                    $display("FAIL outputs t=%0t got={sel,fif,fid,stall,busy,tgt[,cnt]}=%h required=%h",
                             $time, got, exp);
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset with stall request high.
        drive_cycle(0, 0, 0, '0, 0, 1);
        drive_cycle(0, 1, 1, 32'h0000_2222, 1, 1);
        // Taken to 0x1001 with fetch always ready.
        drive_cycle(1, 1, 1, 32'h0000_1001, 1, 0);
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, 0, '0, 1, 0);
        // Fetch stalls 3 cycles; a second taken pulse in the window is ignored.
        drive_cycle(1, 1, 1, 32'h0000_4444, 0, 0);
        drive_cycle(1, 1, 1, 32'h0000_8888, 0, 1);
        drive_cycle(1, 0, 0, '0, 0, 0);
        drive_cycle(1, 1, 1, 32'h0000_9999, 0, 0);
        drive_cycle(1, 1, 1, 32'h0000_aaaa, 1, 1);
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 0, '0, 1, 1);
        // Taken ignored without valid.
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 1, 32'hdead_beef, 1, 0);
        // Reset during DRAIN.
        drive_cycle(1, 1, 1, 32'h0000_3003, 1, 0);
        drive_cycle(1, 0, 0, '0, 1, 0);
        drive_cycle(1, 0, 0, '0, 1, 0);
        drive_cycle(0, 0, 0, '0, 1, 0);
        drive_cycle(1, 0, 0, '0, 1, 0);
        // Back-to-back accepted redirects exercise the statistics counter.
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 1, 1, 32'h0000_0100 + XLEN'(i), 1, 0);
            for (int j = 0; j < FLUSH_DEPTH + 1; j++) drive_cycle(1, 0, 0, '0, 1, 0);
        end
        // Randomized traffic with rare resets.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 2) != 0, XLEN'($urandom()),
                        $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        end
        drive_cycle(1, 0, 0, '0, 1, 0);
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain_queue remaining=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Control-hazard sequencer for the RV32 pipeline.
- Consumes the resolved taken/not-taken decision and target address from the EX stage.
- Drives the PC redirect to the fetch unit, holding it until fetch accepts.
- Kills wrong-path instructions in IF/ID, then drains in-flight fetch responses for a fixed number of cycles.
- Sits between the EX-stage branch/jump logic, the PC/fetch unit and the IF/ID pipeline registers.

## Interface
Parameters:
- XLEN, 32, address width.
- FLUSH_DEPTH, 2, cycles of IF-only flush after the redirect is accepted; legal range 0..7.
- CNT_W, 16, width of the statistics counter (only with the macro).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_Valid_ex  input  1  EX stage holds a valid instruction.
- i_B_J_taken  input  1  EX instruction is a taken branch or a jump.
- i_Target  input  XLEN  branch/jump target from EX.
- i_Imem_ready  input  1  fetch unit accepts a redirect this cycle.
- i_Stall_req  input  1  external stall request (e.g. load-use).
- o_Pc_sel  output  1  select o_Pc_target as next PC.
- o_Pc_target  output  XLEN  registered redirect address.
- o_Flush_if  output  1  invalidate the IF/ID register.
- o_Flush_id  output  1  invalidate the ID/EX register.
- o_Stall  output  1  freeze PC and IF/ID.
- o_Busy  output  1  controller not in IDLE.
- o_Redirect_count  output  CNT_W  accepted redirects (macro only).

## Operation
States are IDLE, REDIRECT and DRAIN, plus a 3-bit drain counter and an XLEN target register.
- IDLE
  - When `i_Valid_ex & i_B_J_taken`: latch the target as `{i_Target[XLEN-1:1],1'b0}` (bit 0 cleared per JALR), then go to REDIRECT.
  - Otherwise stay in IDLE. `i_B_J_taken` is ignored when `i_Valid_ex=0`.
- REDIRECT
  - Outputs: `o_Pc_sel=1`, `o_Flush_if=1`, `o_Flush_id=1`.
  - If `i_Imem_ready=1`, the redirect is accepted:
    - FLUSH_DEPTH=0: go to IDLE.
    - Otherwise: load the counter with FLUSH_DEPTH and go to DRAIN.
  - If `i_Imem_ready=0`: stay in REDIRECT with outputs held and the target unchanged.
- DRAIN
  - Outputs: `o_Flush_if=1` only.
  - Decrement the counter each cycle. When the counter is 1, go to IDLE next edge.
- EX inputs are ignored in REDIRECT and DRAIN, because EX holds wrong-path or bubble content.
- o_Stall is the only combinational output:
  - REDIRECT: `o_Stall = ~i_Imem_ready`.
  - IDLE and DRAIN: `o_Stall = i_Stall_req`.
  - A redirect overrides i_Stall_req.
- `o_Busy = (state != IDLE)`.
- o_Pc_target always shows the target register, including in IDLE.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; target, counter and o_Redirect_count all 0.
  - Outputs o_Pc_sel, o_Flush_if, o_Flush_id, o_Busy = 0; o_Pc_target = 0.
  - o_Stall = i_Stall_req.
- Taken sampled at edge N, fetch ready:
  - REDIRECT outputs are high during cycle N+1.
  - If ready in N+1: DRAIN covers cycles N+2 .. N+1+FLUSH_DEPTH; IDLE at N+2+FLUSH_DEPTH.
  - The earliest next taken is sampled at the edge ending that IDLE cycle.
- Each cycle `i_Imem_ready=0` in REDIRECT adds exactly one cycle.
- Reset asserted mid-REDIRECT or mid-DRAIN returns to IDLE at once; any pending redirect is dropped.
- o_Pc_sel never asserts in the same cycle as the taken input (one-cycle registered latency).

## Configuration
- `BJ_CTRL_STATS_EN` defined:
  - Adds the o_Redirect_count port and its register.
  - Increments by 1 on each accepted redirect (`state==REDIRECT & i_Imem_ready`).
  - Saturates at all-ones; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with `i_Stall_req=1` → all outputs 0 except `o_Stall=1`; o_Pc_target=0x0.
- Taken `i_Target=0x0000_1001`, `i_Imem_ready=1` always, FLUSH_DEPTH=2:
  - Next cycle: o_Pc_sel, o_Flush_if, o_Flush_id = 1 and o_Pc_target=0x0000_1000.
  - Then 2 cycles with only o_Flush_if=1, then IDLE.
- `i_Imem_ready` held 0 for 3 cycles during REDIRECT → REDIRECT lasts 4 cycles with o_Stall=1 for the first 3; a second taken pulse during this window is ignored.
- `i_Valid_ex=0` with `i_B_J_taken=1` → no state change, o_Busy stays 0.
- `i_rst_n` low during DRAIN → o_Busy and o_Flush_if drop at once; o_Pc_target reads 0.
- With `BJ_CTRL_STATS_EN`, CNT_W=2: 5 accepted redirects → count reads 1, 2, 3, 3, 3.
